// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDUop encodings and default latencies shared by the multiply/divide unit.
package mdu_ctrl_pkg;
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_md(input logic [3:0] op);
        return op >= MDU_MULT && op <= MDU_DIVU;
    endfunction
endpackage

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational mult/multu/div/divu producing {hi,lo} and a divide-by-zero flag.
module mdu_arith
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_rs,
    input  logic [WIDTH-1:0]   i_rt,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_div_by_zero
);
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    logic               w_rt_zero, w_ovf;
    logic [WIDTH-1:0]   w_dv_s, w_dv_u, w_q_s, w_r_s, w_q_u, w_r_u;
    logic [2*WIDTH-1:0] w_p_s, w_p_u;

    assign w_rt_zero = i_rt == '0;
    assign w_ovf     = i_rs == MIN_S && &i_rt;
    // MIN/-1 divides by 1 instead, which yields the required quotient MIN and remainder 0
    assign w_dv_s    = (w_rt_zero || w_ovf) ? WIDTH'(1) : i_rt;
    assign w_dv_u    = w_rt_zero ? WIDTH'(1) : i_rt;
    assign w_q_s     = $signed(i_rs) / $signed(w_dv_s);
    assign w_r_s     = $signed(i_rs) % $signed(w_dv_s);
    assign w_q_u     = i_rs / w_dv_u;
    assign w_r_u     = i_rs % w_dv_u;
    assign w_p_s     = $signed({{WIDTH{i_rs[WIDTH-1]}}, i_rs}) * $signed({{WIDTH{i_rt[WIDTH-1]}}, i_rt});
    assign w_p_u     = {{WIDTH{1'b0}}, i_rs} * {{WIDTH{1'b0}}, i_rt};

    always_comb begin
        o_res = i_op == MDU_MULT  ? w_p_s :
                i_op == MDU_MULTU ? w_p_u :
                i_op == MDU_DIV   ? {w_r_s, w_q_s} :
                i_op == MDU_DIVU  ? {w_r_u, w_q_u} : '0;
    end

    assign o_div_by_zero = w_rt_zero && (i_op == MDU_DIV || i_op == MDU_DIVU);
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO, with D-stage stall generation.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             d_md_mf_mt,
    output logic             start,
    output logic             busy,
    output logic             stall_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mdu_out
);
    localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);

    logic [CW-1:0]      r_cnt;
    logic               r_busy, r_pend_dz;
    logic [2*WIDTH-1:0] r_pend;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [2*WIDTH-1:0] w_res;
    logic               w_dz, w_go;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op          (mdu_op),
        .i_rs          (rs_data),
        .i_rt          (rt_data),
        .o_res         (w_res),
        .o_div_by_zero (w_dz)
    );

    assign start = en && is_md(mdu_op);
    assign w_go  = start && !r_busy;

    // The result is captured at issue; the counter only delays its commit to HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_pend    <= '0;
            r_pend_dz <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_go) begin
            r_pend    <= w_res;
            r_pend_dz <= w_dz;
            r_cnt     <= (mdu_op == MDU_MULT || mdu_op == MDU_MULTU) ? CW'(MULT_LAT) : CW'(DIV_LAT);
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                if (!r_pend_dz) {r_hi, r_lo} <= r_pend;
            end
        end else if (en && mdu_op == MDU_MTHI) begin
            r_hi <= rs_data;
        end else if (en && mdu_op == MDU_MTLO) begin
            r_lo <= rs_data;
        end
    end

    assign busy    = r_busy;
    assign stall_d = d_md_mf_mt && (start || r_busy);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign mdu_out = mdu_op == MDU_MFHI ? r_hi : mdu_op == MDU_MFLO ? r_lo : '0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized bench for mdu_ctrl against a timestamp-based reference model.
module tb_mdu_ctrl;
    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0, reset = 1'b1, en = 1'b0, d = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs = '0, rt = '0;
    logic        start, busy, stall_d;
    logic [31:0] hi, lo, mdu_out;

    int total = 0, bad = 0, cyc = 0;
    logic chk_on = 1'b0;

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_act, m_dz;
    int          m_end;

    mdu_ctrl #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .en(en), .mdu_op(op), .rs_data(rs), .rt_data(rt),
        .d_md_mf_mt(d), .start(start), .busy(busy), .stall_d(stall_d),
        .hi(hi), .lo(lo), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (o == 4'd1) return sa * sb;
        if (o == 4'd2) return ua * ub;
        if (b == 0) return 64'd0;
        if (o == 4'd3) return {32'(sa % sb), 32'(sa / sb)};
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: an accepted op commits LAT+1 cycles after its issue cycle; busy while pending
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi <= '0; m_lo <= '0; m_res <= '0; m_act <= 1'b0; m_dz <= 1'b0; m_end <= 0;
        end else if (m_act) begin
            if (cyc + 1 == m_end) begin
                if (!m_dz) {m_hi, m_lo} <= m_res;
                m_act <= 1'b0;
            end
        end else if (en && op >= 4'd1 && op <= 4'd4) begin
            m_res <= ref_res(op, rs, rt);
            m_dz  <= op >= 4'd3 && rt == 0;
            m_act <= 1'b1;
            m_end <= cyc + 1 + (op <= 4'd2 ? ML : DL);
        end else if (en && op == 4'd7) begin
            m_hi <= rs;
        end else if (en && op == 4'd8) begin
            m_lo <= rs;
        end
    end

    always @(negedge clk) begin : cmp
        logic st;
        if (chk_on) begin
            st = en && op >= 4'd1 && op <= 4'd4;
            chk("start", {31'b0, start}, {31'b0, st});
            chk("busy", {31'b0, busy}, {31'b0, m_act});
            chk("stall_d", {31'b0, stall_d}, {31'b0, d && (st || m_act)});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("mdu_out", mdu_out, op == 4'd5 ? m_hi : op == 4'd6 ? m_lo : 32'd0);
        end
    end

    task automatic step(input logic [3:0] o, input logic [31:0] a = 0, input logic [31:0] b = 0,
                        input logic e = 1'b1, input logic dd = 1'b0);
        @(posedge clk);
        #1;
        op = o; rs = a; rt = b; en = e; d = dd;
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b0;
        chk_on = 1'b1;
        #2;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        step(4'd1, 32'd3, 32'hFFFF_FFFE);
        chk("mult_start", {31'b0, start}, 32'h1);
        for (int i = 1; i <= ML; i++) begin
            step(4'd0);
            chk("mult_busy", {31'b0, busy}, 32'h1);
        end
        step(4'd0);
        chk("mult_done_busy", {31'b0, busy}, 32'h0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        step(4'd2, 32'hFFFF_FFFF, 32'd2);
        repeat (ML) step(4'd0);
        step(4'd5);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        chk("mfhi_out", mdu_out, 32'h1);

        step(4'd3, 32'hFFFF_FFF9, 32'd2);
        repeat (DL) step(4'd0);
        step(4'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("model_div_hi", m_hi, 32'hFFFF_FFFF);
        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (DL) step(4'd0);
        step(4'd0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        step(4'd7, 32'h1234);
        step(4'd4, 32'd7, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        for (int i = 1; i <= DL; i++) begin
            step(4'd0);
            chk("dz_busy", {31'b0, busy}, 32'h1);
        end
        step(4'd0);
        chk("dz_busy_end", {31'b0, busy}, 32'h0);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h8000_0000);

        step(4'd3, 32'd100, 32'd7, 1'b1, 1'b1);
        chk("stall_issue", {31'b0, stall_d}, 32'h1);
        for (int i = 1; i <= DL; i++) begin
            if (i == 3) step(4'd8, 32'hDEAD, 32'd0, 1'b1, 1'b1);
            else step(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
            chk("stall_busy", {31'b0, stall_d}, 32'h1);
        end
        step(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("stall_end", {31'b0, stall_d}, 32'h0);
        chk("div2_lo", lo, 32'hE);
        chk("div2_hi", hi, 32'h2);

        step(4'd1, 32'd1, 32'd1, 1'b0);
        chk("en0_start", {31'b0, start}, 32'h0);
        step(4'd0);
        chk("en0_busy", {31'b0, busy}, 32'h0);

        step(4'd1, 32'd5, 32'd6);
        step(4'd0);
        step(4'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(4'd1, 32'd7, 32'd9);
        repeat (ML) step(4'd0);
        step(4'd0);
        chk("post_rst_lo", lo, 32'h3F);
        chk("post_rst_hi", hi, 32'h0);

        step(4'd1, 32'd2, 32'd3);
        repeat (ML) step(4'd0);
        step(4'd3, 32'd9, 32'd2);
        chk("b2b_lo", lo, 32'h6);
        chk("b2b_start", {31'b0, start}, 32'h1);
        step(4'd0);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        repeat (DL - 1) step(4'd0);
        step(4'd0);
        chk("b2b_div_lo", lo, 32'h4);
        chk("b2b_div_hi", hi, 32'h1);

        repeat (600) begin
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk);
                #3 reset = 1'b0;
                #4 reset = 1'b1;
            end else begin
                step(4'($urandom_range(0, 8)), pick(), pick(), $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
            end
        end
        repeat (DL + 2) step(4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
